// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: ALU operations, ONE sub-ops, opcodes,
// sequencer states and decode classes. The ALU and the sequencer both import
// this package so the encodings cannot drift apart.
package cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ALU_OP_W = 2;

  // ALU operation select
  localparam logic [ALU_OP_W-1:0] ALU_ONE  = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_SWAP = 2'b11;

  // Sub-operation carried on alu_a when alu_op = ONE
  localparam logic [DATA_W-1:0] SUBOP_INC = 8'h20;
  localparam logic [DATA_W-1:0] SUBOP_DEC = 8'h40;

  // Opcodes (first instruction byte)
  localparam logic [DATA_W-1:0] OP_STORE   = 8'h01;
  localparam logic [DATA_W-1:0] OP_LOAD    = 8'h02;
  localparam logic [DATA_W-1:0] OP_STOP    = 8'h04;
  localparam logic [DATA_W-1:0] OP_JUMP    = 8'h08;
  localparam logic [DATA_W-1:0] OP_M_STORE = 8'h10;
  localparam logic [DATA_W-1:0] OP_INC     = 8'h20;
  localparam logic [DATA_W-1:0] OP_DEC     = 8'h40;
  localparam logic [DATA_W-1:0] OP_ADD     = 8'h80;
  localparam logic [DATA_W-1:0] OP_SUB     = 8'h81;
  localparam logic [DATA_W-1:0] OP_JZ      = 8'h82;
  localparam logic [DATA_W-1:0] OP_JC      = 8'h83;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_OP,
    ST_FETCH_ARG,
    ST_DECODE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_ALU_ISSUE,
    ST_ALU_WB,
    ST_HALT
  } state_e;

  // What DECODE does with an opcode
  typedef enum logic [3:0] {
    CLS_STORE,
    CLS_LOAD,
    CLS_STOP,
    CLS_JUMP,
    CLS_JZ,
    CLS_JC,
    CLS_M_STORE,
    CLS_ALU_MEM,   // ADD/SUB: operand read from mem[ARG] first
    CLS_ALU_ACC,   // INC/DEC: ALU ONE op on ACC only
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode lookup.
//   opcode    in  : instruction register
//   op_class  out : action class taken in DECODE
//   alu_op    out : ALU operation for ALU-class opcodes
//   alu_subop out : ONE sub-op placed on alu_a for INC/DEC
//   illegal   out : opcode is not in the instruction set
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_e  op_class,
  output logic [1:0] alu_op,
  output logic [7:0] alu_subop,
  output logic       illegal
);

  always_comb begin
    op_class  = CLS_ILLEGAL;
    alu_op    = ALU_ONE;
    alu_subop = 8'h00;
    illegal   = 1'b0;
    case (opcode)
      OP_STORE:   op_class = CLS_STORE;
      OP_LOAD:    op_class = CLS_LOAD;
      OP_STOP:    op_class = CLS_STOP;
      OP_JUMP:    op_class = CLS_JUMP;
      OP_M_STORE: op_class = CLS_M_STORE;
      OP_JZ:      op_class = CLS_JZ;
      OP_JC:      op_class = CLS_JC;
      OP_INC: begin
        op_class  = CLS_ALU_ACC;
        alu_subop = SUBOP_INC;
      end
      OP_DEC: begin
        op_class  = CLS_ALU_ACC;
        alu_subop = SUBOP_DEC;
      end
      OP_ADD: begin
        op_class = CLS_ALU_MEM;
        alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        op_class = CLS_ALU_MEM;
        alu_op   = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit CPU. Owns PC, ACC, IR/ARG and
// the latched flags; sole master of the program/data memory port and the ALU.
//   clk, rst                          : clock, async active-high reset
//   start                             : level, leaves IDLE when high
//   mem_req/we/addr/wdata, rdata/ack  : req/ack memory port (req held until ack)
//   alu_en/op/a/b, alu_out/zero/carry : registered ALU, result one cycle after en
//   pc, acc, flag_z, flag_c           : architectural state
//   halted, illegal                   : HALT state, sticky illegal-opcode flag
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC        = 8'h00,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted,
  output logic       illegal
);

  state_e     state;
  logic [7:0] ir;
  logic [7:0] arg;

  op_class_e  dec_class;
  logic [1:0] dec_alu_op;
  logic [7:0] dec_subop;
  logic       dec_illegal;

  logic       branch_taken_c;
  logic [7:0] fetch_addr_c;

  cpu_decode u_decode (
    .opcode    (ir),
    .op_class  (dec_class),
    .alu_op    (dec_alu_op),
    .alu_subop (dec_subop),
    .illegal   (dec_illegal)
  );

  // Address of the next opcode fetch when leaving DECODE
  always_comb begin
    branch_taken_c = (dec_class == CLS_JUMP) ||
                     ((dec_class == CLS_JZ) && flag_z) ||
                     ((dec_class == CLS_JC) && flag_c);
    fetch_addr_c   = branch_taken_c ? arg : pc;
  end

  // Sequencer; bus and ALU outputs are loaded on entry to the state that uses them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      acc       <= 8'h00;
      ir        <= 8'h00;
      arg       <= 8'h00;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      alu_en    <= 1'b0;
      alu_op    <= ALU_ONE;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
    end else begin
      alu_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH_OP;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end

        ST_FETCH_OP: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            pc       <= pc + 8'd1;
            mem_addr <= pc + 8'd1;
            state    <= ST_FETCH_ARG;
          end
        end

        ST_FETCH_ARG: begin
          if (mem_ack) begin
            arg     <= mem_rdata;
            pc      <= pc + 8'd1;
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          // Default exit: fetch the next (possibly branched-to) instruction
          state    <= ST_FETCH_OP;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= fetch_addr_c;
          pc       <= fetch_addr_c;
          if (dec_illegal) begin
            if (HALT_ON_ILLEGAL) begin
              state   <= ST_HALT;
              mem_req <= 1'b0;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          end else begin
            case (dec_class)
              CLS_STORE: acc <= arg;
              CLS_STOP: begin
                state   <= ST_HALT;
                mem_req <= 1'b0;
                halted  <= 1'b1;
              end
              CLS_LOAD, CLS_ALU_MEM: begin
                state    <= ST_MEM_RD;
                mem_addr <= arg;
              end
              CLS_M_STORE: begin
                state     <= ST_MEM_WR;
                mem_we    <= 1'b1;
                mem_addr  <= arg;
                mem_wdata <= acc;
              end
              CLS_ALU_ACC: begin
                state   <= ST_ALU_ISSUE;
                mem_req <= 1'b0;
                alu_en  <= 1'b1;
                alu_op  <= dec_alu_op;
                alu_a   <= dec_subop;
                alu_b   <= acc;
              end
              default: ;
            endcase
          end
        end

        ST_MEM_RD: begin
          if (mem_ack) begin
            if (dec_class == CLS_LOAD) begin
              acc      <= mem_rdata;
              state    <= ST_FETCH_OP;
              mem_addr <= pc;
            end else begin
              // alu_b doubles as the latched memory operand
              state   <= ST_ALU_ISSUE;
              mem_req <= 1'b0;
              alu_en  <= 1'b1;
              alu_op  <= dec_alu_op;
              alu_a   <= acc;
              alu_b   <= mem_rdata;
            end
          end
        end

        ST_MEM_WR: begin
          if (mem_ack) begin
            state    <= ST_FETCH_OP;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end

        ST_ALU_ISSUE: state <= ST_ALU_WB;

        ST_ALU_WB: begin
          acc      <= alu_out;
          flag_z   <= alu_zero;
          flag_c   <= alu_carry;
          state    <= ST_FETCH_OP;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end

        ST_HALT: ;

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: program table run against a memory
// model with optional wait states and spurious acks plus a registered ALU
// model; expected end states go through a scoreboard queue. Hand sequences
// cover reset state, reset during a write wait, and illegal-as-NOP.
module tb_cpu_seq_ctrl;

  typedef struct packed {
    logic [127:0] prog;      // bytes 0x00..0x0F, first byte in the MSBs
    logic [7:0]   da0, dv0, da1, dv1;
    logic [3:0]   max_wait;
    logic [7:0]   exp_acc;
    logic         exp_z, exp_c;
    logic [7:0]   exp_pc;
    logic         exp_ill;
    logic [7:0]   chk_addr, exp_mem;
    logic [3:0]   exp_alu;
    logic [7:0]   exp_cyc;   // 0 = cycle count not checked
  } vec_t;

  localparam int NV = 12;

  localparam logic [127:0] P_INC   = 128'h0105_2000_0400_0000_0000_0000_0000_0000;
  localparam logic [127:0] P_JC    = 128'h01FF_2000_8310_0400_0000_0000_0000_0000;
  localparam logic [127:0] P_ADD   = 128'h0240_8041_1042_0400_0000_0000_0000_0000;
  localparam logic [127:0] P_ILL   = 128'h0107_5500_0109_0400_0000_0000_0000_0000;
  localparam logic [127:0] P_SUB   = 128'h0101_4000_820A_0133_0400_8120_0400_0000;
  localparam logic [127:0] P_JMP   = 128'h0103_820C_0808_5555_2000_0400_0000_0000;
  localparam logic [127:0] P_WRAP  = 128'h8308_01FF_2000_08FE_0400_0000_0000_0000;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       alu_en, alu_zero, alu_carry;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [7:0] pc, acc;
  logic       flag_z, flag_c, halted, illegal;

  logic       d1_rst, d1_start;
  logic       d1_mem_req, d1_mem_we, d1_mem_ack;
  logic [7:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic       d1_alu_en, d1_alu_zero, d1_alu_carry;
  logic [1:0] d1_alu_op;
  logic [7:0] d1_alu_a, d1_alu_b, d1_alu_out;
  logic [7:0] d1_pc, d1_acc;
  logic       d1_flag_z, d1_flag_c, d1_halted, d1_illegal;

  logic [7:0] mem  [256];
  logic [7:0] mem1 [256];

  int   n_vec = 0;
  int   n_miss = 0;
  int   max_wait = 0;
  bit   spur_en = 1'b0;
  bit   force_wait = 1'b0;
  int   alu_pulses = 0;
  int   alu_run = 0;
  vec_t vecs [NV];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .pc(pc), .acc(acc), .flag_z(flag_z), .flag_c(flag_c),
    .halted(halted), .illegal(illegal)
  );

  cpu_seq_ctrl #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(d1_rst), .start(d1_start),
    .mem_req(d1_mem_req), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(d1_mem_rdata), .mem_ack(d1_mem_ack),
    .alu_en(d1_alu_en), .alu_op(d1_alu_op), .alu_a(d1_alu_a), .alu_b(d1_alu_b),
    .alu_out(d1_alu_out), .alu_zero(d1_alu_zero), .alu_carry(d1_alu_carry),
    .pc(d1_pc), .acc(d1_acc), .flag_z(d1_flag_z), .flag_c(d1_flag_c),
    .halted(d1_halted), .illegal(d1_illegal)
  );

  // Reference ALU: returns {zero, carry, result}; carry is borrow for subtraction
  function automatic logic [9:0] alu_model(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] r;
    case (op)
      2'b01:   r = {1'b0, a} + {1'b0, b};
      2'b10:   r = {1'b0, a} - {1'b0, b};
      2'b00:   r = (a == 8'h40) ? ({1'b0, b} - 9'd1) : ({1'b0, b} + 9'd1);
      default: r = {1'b0, a[3:0], a[7:4]};
    endcase
    return {(r[7:0] == 8'h00), r[8], r[7:0]};
  endfunction

  always @(posedge clk) begin
    if (alu_en)    {alu_zero, alu_carry, alu_out} <= alu_model(alu_op, alu_a, alu_b);
    if (d1_alu_en) {d1_alu_zero, d1_alu_carry, d1_alu_out} <= alu_model(d1_alu_op, d1_alu_a, d1_alu_b);
  end

  // Zero-wait read-only memory for the illegal-as-NOP instance
  assign d1_mem_ack   = d1_mem_req;
  assign d1_mem_rdata = mem1[d1_mem_addr];

  // Memory model for the main instance: random wait states, spurious acks when idle
  bit         busy = 1'b0;
  int         wait_left = 0;
  logic [7:0] snap_addr, snap_wdata;
  logic       snap_we;

  always @(negedge clk) begin
    if (rst) begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      busy      = 1'b0;
    end else if (!mem_req) begin
      busy      = 1'b0;
      mem_ack   = spur_en && ($urandom_range(0, 2) == 0);
      mem_rdata = 8'($urandom);
    end else begin
      if (!busy) begin
        busy       = 1'b1;
        wait_left  = (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
        snap_addr  = mem_addr;
        snap_we    = mem_we;
        snap_wdata = mem_wdata;
      end else begin
        n_vec++;
        if (mem_addr !== snap_addr || mem_we !== snap_we || (snap_we && mem_wdata !== snap_wdata)) begin
          n_miss++;
          $display("FAIL hold_stable: addr/we/wdata %h/%b/%h, required %h/%b/%h",
                   mem_addr, mem_we, mem_wdata, snap_addr, snap_we, snap_wdata);
        end
      end
      if (wait_left == 0 && !(force_wait && mem_we)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        busy      = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (wait_left > 0) wait_left--;
      end
    end
  end

  // alu_en must be a single-cycle strobe
  always @(negedge clk) begin
    if (alu_en) begin
      alu_run++;
      if (alu_run == 1) alu_pulses++;
    end else begin
      if (alu_run != 0) begin
        n_vec++;
        if (alu_run != 1) begin
          n_miss++;
          $display("FAIL alu_en_width: got %0d cycles, required 1", alu_run);
        end
      end
      alu_run = 0;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] prog, input logic [7:0] da0, dv0, da1, dv1,
                              input logic [3:0] mw, input logic [7:0] eacc, input logic ez, ec,
                              input logic [7:0] epc, input logic eill, input logic [7:0] ca, em,
                              input logic [3:0] ealu, input logic [7:0] ecyc);
    vec_t v;
    v.prog = prog; v.da0 = da0; v.dv0 = dv0; v.da1 = da1; v.dv1 = dv1;
    v.max_wait = mw; v.exp_acc = eacc; v.exp_z = ez; v.exp_c = ec; v.exp_pc = epc;
    v.exp_ill = eill; v.chk_addr = ca; v.exp_mem = em; v.exp_alu = ealu; v.exp_cyc = ecyc;
    return v;
  endfunction

  task automatic load_mem(input logic [127:0] prog, input logic [7:0] da0, dv0, da1, dv1);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = prog[127 - 8*i -: 8];
    mem[da0] = dv0;
    mem[da1] = dv1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   cyc;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    max_wait = int'(v.max_wait);
    spur_en = (v.max_wait != 4'd0);
    load_mem(v.prog, v.da0, v.dv0, v.da1, v.dv1);
    @(negedge clk);
    rst = 1'b0;
    alu_pulses = 0;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b1;                       // held high for the whole run
    @(posedge clk);
    #1;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);          // HALT must absorb, start still high
    #1;
    start = 1'b0;
    e = sb_q.pop_front();
    check8($sformatf("v%0d_halted", idx), 8'(halted), 8'h01);
    check8($sformatf("v%0d_acc", idx), acc, e.exp_acc);
    check8($sformatf("v%0d_flag_z", idx), 8'(flag_z), 8'(e.exp_z));
    check8($sformatf("v%0d_flag_c", idx), 8'(flag_c), 8'(e.exp_c));
    check8($sformatf("v%0d_pc", idx), pc, e.exp_pc);
    check8($sformatf("v%0d_illegal", idx), 8'(illegal), 8'(e.exp_ill));
    check8($sformatf("v%0d_mem", idx), mem[e.chk_addr], e.exp_mem);
    check8($sformatf("v%0d_alu_pulses", idx), 8'(alu_pulses), 8'(e.exp_alu));
    if (e.exp_cyc != 8'h00) check8($sformatf("v%0d_cycles", idx), 8'(cyc), e.exp_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check8({tag, "_mem_req"}, 8'(mem_req), 8'h00);
    check8({tag, "_mem_we"}, 8'(mem_we), 8'h00);
    check8({tag, "_mem_addr"}, mem_addr, 8'h00);
    check8({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check8({tag, "_alu_en"}, 8'(alu_en), 8'h00);
    check8({tag, "_alu_op"}, 8'(alu_op), 8'h00);
    check8({tag, "_alu_a"}, alu_a, 8'h00);
    check8({tag, "_alu_b"}, alu_b, 8'h00);
    check8({tag, "_pc"}, pc, 8'h00);
    check8({tag, "_acc"}, acc, 8'h00);
    check8({tag, "_flags"}, 8'({flag_z, flag_c}), 8'h00);
    check8({tag, "_halted"}, 8'(halted), 8'h00);
    check8({tag, "_illegal"}, 8'(illegal), 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; d1_rst = 1'b1; d1_start = 1'b0;
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
    mem1[0] = 8'h01; mem1[1] = 8'h07; mem1[2] = 8'h55; mem1[3] = 8'h00;
    mem1[4] = 8'h20; mem1[5] = 8'h00; mem1[6] = 8'h04; mem1[7] = 8'h00;

    vecs[0]  = mk(P_INC,  8'hF0, 8'h00, 8'hF1, 8'h00, 4'd0, 8'h06, 1'b0, 1'b0, 8'h06, 1'b0, 8'h42, 8'h00, 4'd1, 8'd11);
    vecs[1]  = mk(P_JC,   8'h10, 8'h04, 8'h11, 8'h00, 4'd0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 8'h10, 8'h04, 4'd1, 8'd14);
    vecs[2]  = mk(P_ADD,  8'h40, 8'h30, 8'h41, 8'h12, 4'd0, 8'h42, 1'b0, 1'b0, 8'h08, 1'b0, 8'h42, 8'h42, 4'd1, 8'd17);
    vecs[3]  = mk(P_INC,  8'hF0, 8'h00, 8'hF1, 8'h00, 4'd5, 8'h06, 1'b0, 1'b0, 8'h06, 1'b0, 8'h42, 8'h00, 4'd1, 8'd0);
    vecs[4]  = mk(P_JC,   8'h10, 8'h04, 8'h11, 8'h00, 4'd5, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 8'h10, 8'h04, 4'd1, 8'd0);
    vecs[5]  = mk(P_ADD,  8'h40, 8'h30, 8'h41, 8'h12, 4'd5, 8'h42, 1'b0, 1'b0, 8'h08, 1'b0, 8'h42, 8'h42, 4'd1, 8'd0);
    vecs[6]  = mk(P_ILL,  8'hF0, 8'h00, 8'hF1, 8'h00, 4'd0, 8'h07, 1'b0, 1'b0, 8'h04, 1'b1, 8'h42, 8'h00, 4'd0, 8'd6);
    vecs[7]  = mk(P_SUB,  8'h20, 8'h01, 8'hF0, 8'h00, 4'd0, 8'hFF, 1'b0, 1'b1, 8'h0E, 1'b0, 8'h20, 8'h01, 4'd2, 8'd20);
    vecs[8]  = mk(P_JMP,  8'hF0, 8'h00, 8'hF1, 8'h00, 4'd0, 8'h04, 1'b0, 1'b0, 8'h0C, 1'b0, 8'h42, 8'h00, 4'd1, 8'd17);
    vecs[9]  = mk(P_WRAP, 8'hFE, 8'h01, 8'hFF, 8'hAA, 4'd0, 8'hAA, 1'b1, 1'b1, 8'h0A, 1'b0, 8'hFE, 8'h01, 4'd1, 8'd23);
    vecs[10] = mk(P_SUB,  8'h20, 8'h01, 8'hF0, 8'h00, 4'd5, 8'hFF, 1'b0, 1'b1, 8'h0E, 1'b0, 8'h20, 8'h01, 4'd2, 8'd0);
    vecs[11] = mk(P_WRAP, 8'hFE, 8'h01, 8'hFF, 8'hAA, 4'd5, 8'hAA, 1'b1, 1'b1, 8'h0A, 1'b0, 8'hFE, 8'h01, 4'd1, 8'd0);

    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Illegal opcode treated as NOP on the second instance
    d1_rst = 1'b0;
    @(negedge clk);
    d1_start = 1'b1;
    cyc = 0;
    while (!d1_halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check8("nop_halted", 8'(d1_halted), 8'h01);
    check8("nop_acc", d1_acc, 8'h08);
    check8("nop_pc", d1_pc, 8'h08);
    check8("nop_illegal", 8'(d1_illegal), 8'h00);
    d1_start = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

    // Reset during a stalled M_STORE, then restart from RESET_PC
    @(negedge clk);
    rst = 1'b1;
    max_wait = 0;
    spur_en = 1'b0;
    force_wait = 1'b1;
    load_mem(128'h015A_1042_0400_0000_0000_0000_0000_0000, 8'hF0, 8'h00, 8'hF1, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check8("rw_reach_mem_wr", 8'(mem_req && mem_we), 8'h01);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rw");
    start = 1'b0;
    force_wait = 1'b0;
    spur_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check8("idle_spurious_req", 8'(mem_req), 8'h00);
    check8("idle_spurious_pc", pc, 8'h00);
    check8("rw_mem_untouched", mem[8'h42], 8'h00);
    start = 1'b1;
    @(posedge clk);
    #1;
    check8("restart_req", 8'(mem_req), 8'h01);
    check8("restart_addr", mem_addr, 8'h00);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check8("restart_halted", 8'(halted), 8'h01);
    check8("restart_acc", acc, 8'h5A);
    check8("restart_mem", mem[8'h42], 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
